// File: rtl/program_loader.sv
// Boot loader: frames a host byte stream into 16-bit words for instruction memory and
// holds the CPU PC in reset until a full frame has loaded. Optional feature: CHECKSUM_EN.
module program_loader #(
    parameter logic [7:0]  SYNC_BYTE = 8'hA5,
    parameter int unsigned MAX_WORDS = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic [15:0] instruction_in,
    output logic [15:0] load_address,
    output logic        load_instruction,
    output logic        pc_reset,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam logic [15:0] MAX_N = 16'(MAX_WORDS);

    typedef enum logic [3:0] {
        S_IDLE,
        S_CNT_HI,
        S_CNT_LO,
        S_DATA_HI,
        S_DATA_LO,
        S_WRITE,
        S_RELEASE,
        S_ERROR
`ifdef CHECKSUM_EN
        , S_CHECK
`endif
    } state_t;

    state_t      r_state;
    logic [7:0]  r_cnt_hi;
    logic [15:0] r_count;
    logic [15:0] r_index;
    logic [7:0]  r_hi;
    logic [15:0] r_instruction;
    logic [15:0] r_address;
    logic        r_load;
    logic        r_pc_reset;
    logic        r_busy;
    logic        r_done;
    logic        r_error;
`ifdef CHECKSUM_EN
    logic [7:0]  r_csum;
`endif

    logic        w_xfer;
    logic        w_sync;
    logic [15:0] w_count_n;

    // The loader only stalls the stream while it is writing a word or releasing the CPU.
    assign byte_ready = (r_state != S_WRITE) && (r_state != S_RELEASE);
    assign w_xfer     = byte_valid && byte_ready;
    assign w_sync     = w_xfer && (byte_in == SYNC_BYTE);
    assign w_count_n  = {r_cnt_hi, byte_in};

    assign instruction_in   = r_instruction;
    assign load_address     = r_address;
    assign load_instruction = r_load;
    assign pc_reset         = r_pc_reset;
    assign busy             = r_busy;
    assign done             = r_done;
    assign error            = r_error;

    // All outputs are registered: each transition sets what the next state must show.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_cnt_hi      <= 8'h00;
            r_count       <= 16'h0000;
            r_index       <= 16'h0000;
            r_hi          <= 8'h00;
            r_instruction <= 16'h0000;
            r_address     <= 16'h0000;
            r_load        <= 1'b0;
            r_pc_reset    <= 1'b1;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_error       <= 1'b0;
`ifdef CHECKSUM_EN
            r_csum        <= 8'h00;
`endif
        end else begin
            r_load <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                S_IDLE, S_ERROR: begin
                    if (w_sync) begin
                        r_state    <= S_CNT_HI;
                        r_busy     <= 1'b1;
                        r_error    <= 1'b0;
                        r_pc_reset <= 1'b1;
`ifdef CHECKSUM_EN
                        r_csum     <= 8'h00;
`endif
                    end
                end
                S_CNT_HI: begin
                    if (w_xfer) begin
                        r_cnt_hi <= byte_in;
                        r_state  <= S_CNT_LO;
`ifdef CHECKSUM_EN
                        r_csum   <= r_csum ^ byte_in;
`endif
                    end
                end
                S_CNT_LO: begin
                    if (w_xfer) begin
`ifdef CHECKSUM_EN
                        r_csum <= r_csum ^ byte_in;
`endif
                        if ((w_count_n == 16'h0000) || (w_count_n > MAX_N)) begin
                            r_state <= S_ERROR;
                            r_error <= 1'b1;
                            r_busy  <= 1'b0;
                        end else begin
                            r_count <= w_count_n;
                            r_index <= 16'h0000;
                            r_state <= S_DATA_HI;
                        end
                    end
                end
                S_DATA_HI: begin
                    if (w_xfer) begin
                        r_hi    <= byte_in;
                        r_state <= S_DATA_LO;
`ifdef CHECKSUM_EN
                        r_csum  <= r_csum ^ byte_in;
`endif
                    end
                end
                S_DATA_LO: begin
                    if (w_xfer) begin
                        r_instruction <= {r_hi, byte_in};
                        r_address     <= r_index;
                        r_load        <= 1'b1;
                        r_state       <= S_WRITE;
`ifdef CHECKSUM_EN
                        r_csum        <= r_csum ^ byte_in;
`endif
                    end
                end
                S_WRITE: begin
                    if (r_index == (r_count - 16'd1)) begin
`ifdef CHECKSUM_EN
                        r_state <= S_CHECK;
`else
                        r_state <= S_RELEASE;
                        r_done  <= 1'b1;
`endif
                    end else begin
                        r_index <= r_index + 16'd1;
                        r_state <= S_DATA_HI;
                    end
                end
`ifdef CHECKSUM_EN
                S_CHECK: begin
                    if (w_xfer) begin
                        if (byte_in == r_csum) begin
                            r_state <= S_RELEASE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_ERROR;
                            r_error <= 1'b1;
                            r_busy  <= 1'b0;
                        end
                    end
                end
`endif
                S_RELEASE: begin
                    r_state    <= S_IDLE;
                    r_busy     <= 1'b0;
                    r_pc_reset <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Randomised self-checking bench for program_loader: a byte-counting frame model predicts
// every output each cycle; literal expectations pin the model on the reference frames.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic [15:0] instruction_in;
    logic [15:0] load_address;
    logic        load_instruction;
    logic        pc_reset;
    logic        busy;
    logic        done;
    logic        error;

    int nChecks = 0;
    int nErrors = 0;

    logic [31:0] strobeLog[$];
    int          doneCount = 0;
    logic [7:0]  frameQ[$];

    // model of the expected outputs, advanced once per rising edge
    int          pos = -1;
    int          nWords = 0;
    logic [7:0]  cntHi = 8'h00;
    logic [7:0]  hiByte = 8'h00;
    logic [7:0]  csum = 8'h00;
    logic        mReady = 1'b1;
    logic        mLoad = 1'b0;
    logic        mDone = 1'b0;
    logic        mPc = 1'b1;
    logic        mBusy = 1'b0;
    logic        mError = 1'b0;
    logic [15:0] mInstr = 16'h0000;
    logic [15:0] mAddr = 16'h0000;

    program_loader dut (
        .clk              (clk),
        .reset            (reset),
        .byte_in          (byte_in),
        .byte_valid       (byte_valid),
        .byte_ready       (byte_ready),
        .instruction_in   (instruction_in),
        .load_address     (load_address),
        .load_instruction (load_instruction),
        .pc_reset         (pc_reset),
        .busy             (busy),
        .done             (done),
        .error            (error)
    );

    always #5 clk = ~clk;

    // The model counts bytes since the sync marker: positions 1-2 are the count,
    // every second data byte completes a word, and anything after the last word is the checksum.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            pos = -1; nWords = 0; cntHi = 8'h00; hiByte = 8'h00; csum = 8'h00;
            mReady = 1'b1; mLoad = 1'b0; mDone = 1'b0; mPc = 1'b1; mBusy = 1'b0;
            mError = 1'b0; mInstr = 16'h0000; mAddr = 16'h0000;
        end else begin
            bit xfer;
            bit wasLoad;
            bit wasDone;
            int k;
            xfer = byte_valid && mReady;
            wasLoad = mLoad;
            wasDone = mDone;
            mLoad = 1'b0;
            mDone = 1'b0;
            if (wasDone) begin
                mPc = 1'b0; mBusy = 1'b0; pos = -1;
            end else if (wasLoad) begin
`ifndef CHECKSUM_EN
                if (int'(mAddr) == nWords - 1) mDone = 1'b1;
`endif
            end else if (xfer) begin
                if (pos < 0) begin
                    if (byte_in == 8'hA5) begin
                        pos = 0; mBusy = 1'b1; mError = 1'b0; mPc = 1'b1; csum = 8'h00;
                    end
                end else begin
                    pos++;
                    if (pos == 1) begin
                        cntHi = byte_in; csum ^= byte_in;
                    end else if (pos == 2) begin
                        nWords = int'({cntHi, byte_in});
                        csum ^= byte_in;
                        if (nWords == 0 || nWords > 256) begin
                            mError = 1'b1; mBusy = 1'b0; pos = -1;
                        end
                    end else if (pos <= 2 + 2 * nWords) begin
                        csum ^= byte_in;
                        k = pos - 3;
                        if (k % 2 == 0) hiByte = byte_in;
                        else begin
                            mLoad = 1'b1; mInstr = {hiByte, byte_in}; mAddr = 16'(k / 2);
                        end
                    end else begin
                        if (byte_in == csum) mDone = 1'b1;
                        else begin
                            mError = 1'b1; mBusy = 1'b0; pos = -1;
                        end
                    end
                end
            end
            mReady = !(mLoad || mDone);
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nErrors++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Every cycle, compare all outputs against the model and log what the DUT wrote.
    always @(negedge clk) begin
        checkOutput("byte_ready", 32'(byte_ready), 32'(mReady));
        checkOutput("load_instruction", 32'(load_instruction), 32'(mLoad));
        checkOutput("instruction_in", 32'(instruction_in), 32'(mInstr));
        checkOutput("load_address", 32'(load_address), 32'(mAddr));
        checkOutput("pc_reset", 32'(pc_reset), 32'(mPc));
        checkOutput("busy", 32'(busy), 32'(mBusy));
        checkOutput("done", 32'(done), 32'(mDone));
        checkOutput("error", 32'(error), 32'(mError));
        if (load_instruction === 1'b1) strobeLog.push_back({load_address, instruction_in});
        if (done === 1'b1) doneCount++;
    end

    // Offer one byte until the loader takes it; gaps randomly drop byte_valid.
    task automatic applyStimulus(input logic [7:0] b, input bit gaps);
        bit sent = 1'b0;
        int tries = 0;
        while (!sent) begin
            @(negedge clk);
            byte_in = b;
            byte_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            sent = byte_valid && byte_ready;
            tries++;
            if (!sent && tries > 64) begin
                nChecks++;
                nErrors++;
                $display("[TB] FAIL byte_accept: byte %h not taken after %0d cycles", b, tries);
                return;
            end
        end
    endtask

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(negedge clk);
            byte_valid = 1'b0;
            byte_in = 8'($urandom);
        end
    endtask

    task automatic sendQueue(input bit gaps, input int first, input int last);
        for (int i = first; i <= last; i++) applyStimulus(frameQ[i], gaps);
    endtask

    task automatic sendAll(input bit gaps);
        sendQueue(gaps, 0, frameQ.size() - 1);
    endtask

    task automatic addChecksum();
`ifdef CHECKSUM_EN
        logic [7:0] x = 8'h00;
        for (int i = 1; i < frameQ.size(); i++) x ^= frameQ[i];
        frameQ.push_back(x);
`endif
    endtask

    task automatic buildRandomFrame(input int n);
        frameQ = {8'hA5, 8'(n >> 8), 8'(n)};
        for (int i = 0; i < 2 * n; i++) frameQ.push_back(8'($urandom));
        addChecksum();
    endtask

    task automatic buildFrameOne();
        frameQ = {8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
        addChecksum();
    endtask

    task automatic resetPulse();
        @(negedge clk);
        #2 reset = 1'b1;
        byte_valid = 1'b0;
        @(negedge clk);
        #2 reset = 1'b0;
    endtask

    task automatic checkFrameOneLog(input string tag);
        checkOutput({tag, "_count"}, 32'(strobeLog.size()), 32'd2);
        if (strobeLog.size() == 2) begin
            checkOutput({tag, "_w0"}, strobeLog[0], 32'h0000_1234);
            checkOutput({tag, "_w1"}, strobeLog[1], 32'h0001_ABCD);
        end
    endtask

    initial begin
        int doneBefore;
        reset = 1'b1;
        byte_valid = 1'b0;
        byte_in = 8'h00;
        repeat (2) @(negedge clk);
        checkOutput("rst_ready", 32'(byte_ready), 32'd1);
        checkOutput("rst_pc_reset", 32'(pc_reset), 32'd1);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_error", 32'(error), 32'd0);
        checkOutput("rst_addr", 32'(load_address), 32'd0);
        #2 reset = 1'b0;

        $display("[TB] reference two-word frame");
        strobeLog.delete();
        doneBefore = doneCount;
        buildFrameOne();
        sendAll(1'b0);
        idleCycles(4);
        checkFrameOneLog("t1");
        checkOutput("t1_done", 32'(doneCount - doneBefore), 32'd1);
        checkOutput("t1_pc_reset", 32'(pc_reset), 32'd0);

        $display("[TB] junk before sync, one-word frame");
        strobeLog.delete();
        frameQ = {8'h00, 8'hFF};
        sendAll(1'b0);
        frameQ = {8'hA5, 8'h00, 8'h01, 8'hBE, 8'hEF};
        addChecksum();
        sendAll(1'b0);
        idleCycles(4);
        checkOutput("t2_count", 32'(strobeLog.size()), 32'd1);
        if (strobeLog.size() == 1) checkOutput("t2_w0", strobeLog[0], 32'h0000_BEEF);
        checkOutput("t2_error", 32'(error), 32'd0);

        $display("[TB] rejected word counts");
        strobeLog.delete();
        frameQ = {8'hA5, 8'h00, 8'h00};
        sendAll(1'b0);
        idleCycles(3);
        checkOutput("t3_zero_error", 32'(error), 32'd1);
        checkOutput("t3_zero_pc", 32'(pc_reset), 32'd1);
        frameQ = {8'hA5, 8'h01, 8'h01, 8'h12, 8'h34};
        sendAll(1'b0);
        idleCycles(3);
        checkOutput("t3_big_error", 32'(error), 32'd1);
        checkOutput("t3_strobes", 32'(strobeLog.size()), 32'd0);
        buildFrameOne();
        sendAll(1'b0);
        idleCycles(4);
        checkOutput("t3_recover_error", 32'(error), 32'd0);
        checkOutput("t3_recover_pc", 32'(pc_reset), 32'd0);

        $display("[TB] reference frame with random valid gaps");
        strobeLog.delete();
        buildFrameOne();
        sendAll(1'b1);
        idleCycles(4);
        checkFrameOneLog("t4");

        $display("[TB] reset mid-frame");
        frameQ = {8'hA5, 8'h00, 8'h02};
        sendAll(1'b0);
        resetPulse();
        checkOutput("t5_pc_reset", 32'(pc_reset), 32'd1);
        checkOutput("t5_busy", 32'(busy), 32'd0);
        checkOutput("t5_ready", 32'(byte_ready), 32'd1);
        strobeLog.delete();
        buildFrameOne();
        sendAll(1'b1);
        idleCycles(4);
        checkFrameOneLog("t5");

        $display("[TB] maximum length frame");
        strobeLog.delete();
        buildRandomFrame(256);
        sendAll(1'b0);
        idleCycles(4);
        checkOutput("max_count", 32'(strobeLog.size()), 32'd256);
        if (strobeLog.size() == 256) checkOutput("max_last_addr", 32'(strobeLog[255][31:16]), 32'd255);
        checkOutput("max_pc_reset", 32'(pc_reset), 32'd0);

        $display("[TB] random frames");
        for (int f = 0; f < 8; f++) begin
            int nJunk = $urandom_range(0, 3);
            for (int j = 0; j < nJunk; j++) begin
                logic [7:0] jb = 8'($urandom);
                if (jb == 8'hA5) jb = 8'h5A;
                applyStimulus(jb, 1'b0);
            end
            buildRandomFrame($urandom_range(1, 6));
            sendAll($urandom_range(0, 1) == 1);
            idleCycles($urandom_range(3, 6));
        end

        $display("[TB] reload holds the CPU");
        buildRandomFrame(3);
        sendQueue(1'b0, 0, 1);
        idleCycles(2);
        checkOutput("reload_pc_mid", 32'(pc_reset), 32'd1);
        checkOutput("reload_busy_mid", 32'(busy), 32'd1);
        sendQueue(1'b1, 2, frameQ.size() - 1);
        idleCycles(4);
        checkOutput("reload_pc_after", 32'(pc_reset), 32'd0);

`ifdef CHECKSUM_EN
        $display("[TB] bad checksum");
        doneBefore = doneCount;
        frameQ = {8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00};
        sendAll(1'b0);
        idleCycles(4);
        checkOutput("csum_error", 32'(error), 32'd1);
        checkOutput("csum_done", 32'(doneCount - doneBefore), 32'd0);
        checkOutput("csum_pc_reset", 32'(pc_reset), 32'd1);
`endif

        idleCycles(2);
        $display("== %0d vectors applied, %0d miscompares ==", nChecks, nErrors);
        $finish;
    end

endmodule
